// File: rtl/farm_sensor_conditioner_if.sv
// rtl/farm_sensor_conditioner_if.sv - sensor/lamp inputs and conditioned request outputs
interface farm_sensor_conditioner_if;
  logic       sensor_raw;
  logic [2:0] light_farm;
  logic       req;
  logic [7:0] wait_cnt;
  logic [2:0] state_dbg;

  // Traffic-side driver: owns the loop and lamp code, observes the request
  modport master (
    output sensor_raw,
    output light_farm,
    input  req,
    input  wait_cnt,
    input  state_dbg
  );

  // Conditioner side
  modport slave (
    input  sensor_raw,
    input  light_farm,
    output req,
    output wait_cnt,
    output state_dbg
  );
endinterface

// File: rtl/farm_sensor_conditioner.sv
// rtl/farm_sensor_conditioner.sv - debounced, latched farm-road vehicle request with holdoff
module farm_sensor_conditioner #(
  parameter int TICK_DIV      = 4,
  parameter int DEB_TICKS     = 2,
  parameter int HOLDOFF_TICKS = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  farm_sensor_conditioner_if.slave bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam int HW = (HOLDOFF_TICKS > 1) ? $clog2(HOLDOFF_TICKS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_TICKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_QUAL  = 3'b001,
    ST_REQ   = 3'b010,
    ST_SERVE = 3'b011,
    ST_HOLD  = 3'b100
  } state_t;

  logic          s_meta_q;
  logic          s_sync_q;
  logic [TW-1:0] div_q;
  logic          tick;
  logic          green;
  state_t        state_q;
  logic [DW-1:0] deb_q;
  logic [HW-1:0] hold_q;
  logic [7:0]    wait_q;
  logic          req_q;

  assign tick  = (div_q == TICK_LAST);
  // Anything other than the clean green code counts as not-green
  assign green = (bus.light_farm == 3'b001);

  // Two-flop synchronizer for the asynchronous loop input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta_q <= 1'b0;
      s_sync_q <= 1'b0;
    end else begin
      s_meta_q <= bus.sensor_raw;
      s_sync_q <= s_meta_q;
    end
  end

  // Free-running tick divider, wraps at TICK_DIV-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + TW'(1);
    end
  end

  // Request FSM; a state exit on a tick cycle takes priority over counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      deb_q   <= '0;
      hold_q  <= '0;
      wait_q  <= 8'd0;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s_sync_q) begin
            state_q <= ST_QUAL;
            deb_q   <= '0;
          end
        end
        ST_QUAL: begin
          if (!s_sync_q) begin
            state_q <= ST_IDLE;
          end else if (tick) begin
            if (deb_q == DEB_LAST) begin
              state_q <= ST_REQ;
              wait_q  <= 8'd0;
              req_q   <= 1'b1;
            end else begin
              deb_q <= deb_q + DW'(1);
            end
          end
        end
        ST_REQ: begin
          // Latched: only a green lamp releases the request
          if (green) begin
            state_q <= ST_SERVE;
            req_q   <= 1'b0;
          end else if (tick && (wait_q != 8'hFF)) begin
            wait_q <= wait_q + 8'd1;
          end
        end
        ST_SERVE: begin
          if (!green) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            if (hold_q == HOLD_LAST) begin
              state_q <= ST_IDLE;
            end else begin
              hold_q <= hold_q + HW'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req       = req_q;
  assign bus.wait_cnt  = wait_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_farm_sensor_conditioner.sv
// tb/tb_farm_sensor_conditioner.sv - scoreboard bench for farm_sensor_conditioner
module tb_farm_sensor_conditioner;

  localparam int TICK_DIV      = 4;
  localparam int DEB_TICKS     = 2;
  localparam int HOLDOFF_TICKS = 5;

  localparam int M_IDLE  = 0;
  localparam int M_QUAL  = 1;
  localparam int M_REQ   = 2;
  localparam int M_SERVE = 3;
  localparam int M_HOLD  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  farm_sensor_conditioner_if bus ();

  farm_sensor_conditioner #(
    .TICK_DIV      (TICK_DIV),
    .DEB_TICKS     (DEB_TICKS),
    .HOLDOFF_TICKS (HOLDOFF_TICKS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int req;
    int wc;
    int st;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase, counters and a cycle count since reset release
  int m_state, m_deb, m_hold, m_wait, m_cyc;
  bit m_s1, m_s2;

  task automatic model_reset();
    m_state = M_IDLE;
    m_deb   = 0;
    m_hold  = 0;
    m_wait  = 0;
    m_cyc   = 0;
    m_s1    = 0;
    m_s2    = 0;
  endtask

  task automatic model_step();
    bit s, tk, grn;
    s   = m_s2;
    tk  = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
    grn = (bus.light_farm == 3'b001);
    m_s2 = m_s1;
    m_s1 = bus.sensor_raw;
    m_cyc++;
    if (m_state == M_IDLE) begin
      if (s) begin m_state = M_QUAL; m_deb = 0; end
    end else if (m_state == M_QUAL) begin
      if (!s) m_state = M_IDLE;
      else if (tk) begin
        if (m_deb == DEB_TICKS - 1) begin m_state = M_REQ; m_wait = 0; end
        else m_deb++;
      end
    end else if (m_state == M_REQ) begin
      if (grn) m_state = M_SERVE;
      else if (tk) m_wait = (m_wait >= 255) ? 255 : m_wait + 1;
    end else if (m_state == M_SERVE) begin
      if (!grn) begin m_state = M_HOLD; m_hold = 0; end
    end else begin
      if (tk) begin
        if (m_hold == HOLDOFF_TICKS - 1) m_state = M_IDLE;
        else m_hold++;
      end
    end
  endtask

  always @(negedge rst_n) model_reset();

  // Model advances on each edge and queues what the DUT should show
  always @(posedge clk) begin
    exp_t e;
    if (!rst_n) model_reset();
    else model_step();
    e.req = (m_state == M_REQ) ? 1 : 0;
    e.wc  = m_wait;
    e.st  = m_state;
    exp_q.push_back(e);
  end

  // Monitor samples on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("mon_req", int'(bus.req), e.req);
      check("mon_wait_cnt", int'(bus.wait_cnt), e.wc);
      check("mon_state", int'(bus.state_dbg), e.st);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(input string name, input int budget);
    int n;
    n = 0;
    while (bus.req !== 1'b1 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, int'(bus.req), 1);
  endtask

  function automatic logic [2:0] rand_light();
    logic [2:0] codes [8];
    codes = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b111, 3'b011, 3'b101, 3'b110};
    if ($urandom_range(0, 9) < 3) return 3'b001;
    return codes[$urandom_range(0, 7)];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.sensor_raw = 1'b0;
    bus.light_farm = 3'b100;
    #1 rst_n = 1'b0;
    #2;
    check("rst_req", int'(bus.req), 0);
    check("rst_wait_cnt", int'(bus.wait_cnt), 0);
    check("rst_state", int'(bus.state_dbg), 0);
    cyc(3);
    #1 rst_n = 1'b1;

    // Debounce into REQ
    bus.sensor_raw = 1'b1;
    wait_req("debounce_req", 40);
    check("debounce_state", int'(bus.state_dbg), 2);

    // Latch, then serve
    bus.sensor_raw = 1'b0;
    cyc(10);
    #1 check("latch_req", int'(bus.req), 1);
    bus.light_farm = 3'b001;
    @(negedge clk); #1;
    check("serve_req", int'(bus.req), 0);
    check("serve_state", int'(bus.state_dbg), 3);

    // Holdoff with sensor held, then restart
    bus.light_farm = 3'b100;
    bus.sensor_raw = 1'b1;
    cyc(2); #1;
    check("hold_state", int'(bus.state_dbg), 4);
    check("hold_req", int'(bus.req), 0);
    wait_req("holdoff_restart_req", 80);

    // Drain back to IDLE
    bus.light_farm = 3'b001;
    cyc(3);
    bus.light_farm = 3'b100;
    bus.sensor_raw = 1'b0;
    cyc(40); #1;
    check("drain_state", int'(bus.state_dbg), 0);

    // Glitch reject
    bus.sensor_raw = 1'b1;
    cyc(5);
    bus.sensor_raw = 1'b0;
    cyc(6); #1;
    check("glitch_state", int'(bus.state_dbg), 0);
    check("glitch_req", int'(bus.req), 0);

    // Randomized bursts of sensor and lamp activity
    repeat (300) begin
      bus.sensor_raw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) bus.light_farm = rand_light();
      cyc($urandom_range(1, 15));
    end

    // Saturation
    bus.light_farm = 3'b100;
    bus.sensor_raw = 1'b1;
    wait_req("sat_enter_req", 200);
    bus.sensor_raw = 1'b0;
    cyc(1250); #1;
    check("sat_wait_cnt", int'(bus.wait_cnt), 255);
    cyc(40); #1;
    check("sat_hold_wait_cnt", int'(bus.wait_cnt), 255);
    check("sat_req", int'(bus.req), 1);

    // Asynchronous reset mid-REQ, observed before the next edge
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", int'(bus.req), 0);
    check("async_rst_wait_cnt", int'(bus.wait_cnt), 0);
    check("async_rst_state", int'(bus.state_dbg), 0);
    cyc(2);
    #1 rst_n = 1'b1;
    cyc(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/farm_sensor_conditioner.md
FARM_SENSOR_CONDITIONER -- requirements
Module: farm_sensor_conditioner

Interface
REQ-001 Parameter TICK_DIV, default 4, clk cycles per timing tick (4 for simulation, 50000000 for a 50 MHz board).
REQ-002 Parameter DEB_TICKS, default 2, consecutive ticks the sensor must stay high before a request is raised.
REQ-003 Parameter HOLDOFF_TICKS, default 5, ticks after farm service during which the sensor is ignored.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 sensor_raw  input  1  raw farm-road vehicle loop, asynchronous to clk, may bounce.
REQ-007 light_farm  input  3  farm lamp code from the traffic controller: 100 red, 010 yellow, 001 green.
REQ-008 req  output  1  conditioned vehicle request, drives the controller's sensor input C.
REQ-009 wait_cnt  output  8  ticks spent in the request state on the current or most recent request.
REQ-010 state_dbg  output  3  current state encoding.

Function
REQ-011 sensor_raw SHALL pass through a 2-flop synchronizer; only the second flop (s_sync) SHALL be used internally.
REQ-012 The tick divider SHALL count 0..TICK_DIV-1 and wrap, run freely from reset, and pulse tick for one cycle when the count equals TICK_DIV-1.
REQ-013 States SHALL be IDLE=000, QUAL=001, REQ=010, SERVE=011, HOLD=100; any other encoding SHALL go to IDLE on the next clock.
REQ-014 IDLE: if s_sync=1, go to QUAL and clear deb_cnt.
REQ-015 QUAL: s_sync=0 in any cycle returns to IDLE.
REQ-016 QUAL: a tick with s_sync=1 increments deb_cnt.
REQ-017 QUAL: a tick with s_sync=1 and deb_cnt=DEB_TICKS-1 goes to REQ and clears wait_cnt.
REQ-018 REQ: the request is latched; s_sync falling SHALL NOT leave REQ.
REQ-019 REQ: light_farm=001 goes to SERVE.
REQ-020 REQ: each tick increments wait_cnt, saturating at 255 with no wrap.
REQ-021 SERVE: light_farm other than 001 goes to HOLD and clears hold_cnt.
REQ-022 HOLD: s_sync is ignored; each tick increments hold_cnt.
REQ-023 HOLD: a tick with hold_cnt=HOLDOFF_TICKS-1 goes to IDLE.
REQ-024 req SHALL be a registered Moore output: 1 exactly when state=REQ, 0 in all other states.
REQ-025 wait_cnt SHALL hold its value outside REQ until the next entry to REQ.
REQ-026 light_farm values other than 001 (including 000 and non-one-hot codes) SHALL be treated as not-green.
REQ-027 A tick and a state exit in the same cycle: the state exit has priority and the counter belonging to the exited state is not incremented.

Reset
REQ-028 While rst_n=0, all of the following SHALL be 0: state=IDLE, req, wait_cnt, deb_cnt, hold_cnt, the tick divider and both synchronizer flops.
REQ-029 Reset asserted mid-operation (any state) SHALL force the REQ-028 values immediately, without waiting for a clock edge.
REQ-030 After rst_n deasserts, the first tick SHALL occur on the TICK_DIV-th rising clk edge.

Verification (TICK_DIV=4, DEB_TICKS=2, HOLDOFF_TICKS=5)
REQ-031 Debounce: sensor_raw held 1 -> req rises one cycle after the second tick following entry to QUAL, and state_dbg=010.
REQ-032 Glitch reject: sensor_raw 1 for 5 cycles then 0 -> req stays 0 and the state returns to 000.
REQ-033 Latch and serve:
- In REQ, drop sensor_raw -> req stays 1.
- Then light_farm=001 -> req=0 the next cycle and state=011.
- wait_cnt equals the number of ticks elapsed in REQ.
REQ-034 Holdoff: after light_farm returns to 100 with sensor_raw held 1 -> req stays 0 for 5 ticks, then the QUAL/REQ sequence restarts.
REQ-035 Saturation: hold REQ for 300 ticks with light_farm=100 -> wait_cnt=255 and remains 255.
REQ-036 Reset mid-REQ: pulse rst_n low -> req=0, wait_cnt=0 and state_dbg=000 while rst_n is low, before the next clk edge.
